// File: rtl/dcache_wb.sv
// dcache_wb: write-back, write-allocate, direct-mapped data cache with line
// writeback/refill over the cs/ack memory handshake and hit/miss counters.
module dcache_wb #(
    parameter int ADDR_W   = 10,
    parameter int INDEX_W  = 2,
    parameter int OFFSET_W = 2,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              wea,
    input  logic [ADDR_W-1:0] addra,
    input  logic [31:0]       dina,
    output logic [31:0]       douta,
    output logic              ack,
    output logic              mem_cs,
    output logic              mem_wea,
    output logic [ADDR_W-1:0] mem_addra,
    output logic [31:0]       mem_dina,
    input  logic [31:0]       mem_douta,
    input  logic              mem_ack,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);
    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
    localparam int LINES = 1 << INDEX_W;
    localparam int WORDS = 1 << OFFSET_W;

    typedef enum logic [1:0] {IDLE, WBACK, REFILL} state_t;

    state_t state, state_nx;
    logic [31:0]         data [LINES][WORDS];
    logic [TAG_W-1:0]    tag_arr [LINES];
    logic [LINES-1:0]    valid, dirty;
    logic [OFFSET_W-1:0] wc;
    logic [TAG_W-1:0]    tag;
    logic [INDEX_W-1:0]  idx;
    logic [OFFSET_W-1:0] off;
    logic                hit, miss, xfer, last;

    assign tag  = addra[ADDR_W-1 -: TAG_W];
    assign idx  = addra[OFFSET_W +: INDEX_W];
    assign off  = addra[OFFSET_W-1:0];
    assign hit  = valid[idx] & (tag_arr[idx] == tag);
    assign miss = (state == IDLE) & cs & ~hit;
    assign xfer = mem_cs & mem_ack;
    assign last = xfer & (&wc);

    always_comb begin
        ack       = (state == IDLE) & cs & hit;
        douta     = data[idx][off];
        mem_cs    = state != IDLE;
        mem_wea   = state == WBACK;
        mem_addra = mem_wea ? {tag_arr[idx], idx, wc} : {tag, idx, wc};
        mem_dina  = data[idx][wc];
        state_nx  = miss ? ((valid[idx] & dirty[idx]) ? WBACK : REFILL)
                  : last ? ((state == WBACK) ? REFILL : IDLE)
                  : state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wc       <= '0;
            valid    <= '0;
            dirty    <= '0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            state <= state_nx;
            wc    <= miss ? '0 : xfer ? wc + OFFSET_W'(1) : wc;
            if (ack)
                hit_cnt <= hit_cnt + CNT_W'(1);
            if (miss)
                miss_cnt <= miss_cnt + CNT_W'(1);
            if (ack & wea)
                dirty[idx] <= 1'b1;
            // Finishing either a writeback or a refill leaves the line clean
            if (last)
                dirty[idx] <= 1'b0;
            if (last & ~mem_wea)
                valid[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (ack & wea)
            data[idx][off] <= dina;
        if (xfer & ~mem_wea)
            data[idx][wc] <= mem_douta;
        if (last & ~mem_wea)
            tag_arr[idx] <= tag;
    end
endmodule

// File: tb/tb_dcache_wb.sv
// tb_dcache_wb: directed scoreboard bench for dcache_wb against a memory
// model that acks after two wait cycles and can be held off on demand.
module tb_dcache_wb;
    localparam int L = 2;

    typedef struct packed {
        logic        w;
        logic [9:0]  a;
        logic [31:0] d;
    } xact_t;

    logic        clk = 1'b0, rst = 1'b1, cs = 1'b0, wea = 1'b0, hold = 1'b0;
    logic [9:0]  addra = '0;
    logic [31:0] dina = '0;
    logic [31:0] douta, mem_dina, mem_douta, hit_cnt, miss_cnt;
    logic        ack, mem_cs, mem_wea;
    logic        mem_ack = 1'b0;
    logic [9:0]  mem_addra;
    logic [31:0] mem [1024];
    logic        wr_done [1024] = '{default: 1'b0};
    logic [31:0] shadow [1024];
    xact_t       exp_mem [$];
    logic [31:0] exp_rd [$];
    int          cnt = 0;
    int          checks = 0, errors = 0;

    dcache_wb dut (
        .clk(clk), .rst(rst), .cs(cs), .wea(wea), .addra(addra), .dina(dina),
        .douta(douta), .ack(ack), .mem_cs(mem_cs), .mem_wea(mem_wea),
        .mem_addra(mem_addra), .mem_dina(mem_dina), .mem_douta(mem_douta),
        .mem_ack(mem_ack), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input logic [9:0] a);
        return 32'hC0DE0000 | {22'b0, a};
    endfunction

    function automatic logic [31:0] mem_rd(input logic [9:0] a);
        return wr_done[a] ? mem[a] : init_val(a);
    endfunction

    assign mem_douta = mem_rd(mem_addra);

    always @(posedge clk) begin
        if (mem_ack) begin
            mem_ack <= 1'b0;
            cnt     <= 0;
            if (mem_cs && mem_wea) begin
                mem[mem_addra]     <= mem_dina;
                wr_done[mem_addra] <= 1'b1;
            end
        end else if (!mem_cs) begin
            cnt <= 0;
        end else if (!hold) begin
            if (cnt == L - 1) begin
                mem_ack <= 1'b1;
                cnt     <= 0;
            end else begin
                cnt <= cnt + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        xact_t x;
        logic [31:0] r;
        if (!rst) begin
            if (mem_cs && mem_ack) begin
                checks++;
                assert (exp_mem.size() != 0) else begin
                    errors++;
                    $error("FAIL mem_unexpected: observed transfer at %h expected none", mem_addra);
                end
                if (exp_mem.size() != 0) begin
                    x = exp_mem.pop_front();
                    chk("mem_wea", 32'(mem_wea), 32'(x.w));
                    chk("mem_addra", 32'(mem_addra), 32'(x.a));
                    if (x.w)
                        chk("mem_dina", mem_dina, x.d);
                end
            end
            if (ack && !wea) begin
                checks++;
                assert (exp_rd.size() != 0) else begin
                    errors++;
                    $error("FAIL rd_unexpected: observed load ack %h expected none", douta);
                end
                if (exp_rd.size() != 0) begin
                    r = exp_rd.pop_front();
                    chk("douta", douta, r);
                end
            end
        end
    end

    task automatic push_line(input logic w, input logic [9:0] base);
        for (int i = 0; i < 4; i++)
            exp_mem.push_back('{w: w, a: base + 10'(i), d: shadow[base + 10'(i)]});
    endtask

    task automatic start(input logic w, input logic [9:0] a, input logic [31:0] d);
        cs = 1'b1;
        wea = w;
        addra = a;
        dina = d;
        if (w)
            shadow[a] = d;
        else
            exp_rd.push_back(shadow[a]);
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack && n < 300);
        chk("ack_timeout", 32'(ack), 32'd1);
        @(posedge clk);
        #1;
        cs = 1'b0;
        wea = 1'b0;
    endtask

    task automatic access(input logic w, input logic [9:0] a, input logic [31:0] d, output int n);
        start(w, a, d);
        wait_ack(n);
    endtask

    initial begin
        int n, k;
        logic [9:0]  a0;
        logic [31:0] d0;
        for (int i = 0; i < 1024; i++)
            shadow[i] = init_val(10'(i));
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_mem_cs", 32'(mem_cs), 32'd0);
        chk("rst_mem_wea", 32'(mem_wea), 32'd0);
        chk("rst_hit", hit_cnt, 32'd0);
        chk("rst_miss", miss_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        push_line(1'b0, 10'h004);
        access(1'b0, 10'h005, 32'h0, n);
        chk("cold_lat", 32'(n), 32'd14);
        chk("cold_miss", miss_cnt, 32'd1);
        chk("cold_hit", hit_cnt, 32'd1);

        access(1'b0, 10'h006, 32'h0, n);
        chk("hit_lat", 32'(n), 32'd1);
        chk("hit_hit", hit_cnt, 32'd2);

        access(1'b1, 10'h006, 32'hDEADBEEF, n);
        chk("st_lat", 32'(n), 32'd1);
        chk("st_miss", miss_cnt, 32'd1);
        push_line(1'b1, 10'h004);
        push_line(1'b0, 10'h044);
        access(1'b0, 10'h046, 32'h0, n);
        chk("dirty_lat", 32'(n), 32'd26);
        chk("wb_mem6", mem_rd(10'h006), 32'hDEADBEEF);
        chk("dirty_miss", miss_cnt, 32'd2);
        chk("dirty_hit", hit_cnt, 32'd4);

        push_line(1'b0, 10'h010);
        access(1'b1, 10'h011, 32'h12345678, n);
        chk("stmiss_lat", 32'(n), 32'd14);
        chk("stmiss_miss", miss_cnt, 32'd3);
        access(1'b0, 10'h011, 32'h0, n);
        chk("stmiss_rd_lat", 32'(n), 32'd1);
        chk("stmiss_hit", hit_cnt, 32'd6);

        push_line(1'b1, 10'h010);
        push_line(1'b0, 10'h050);
        start(1'b0, 10'h051, 32'h0);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(mem_cs && mem_wea && mem_ack) && k < 100);
        chk("wb_first_ack", 32'(mem_cs & mem_wea & mem_ack), 32'd1);
        @(negedge clk);
        hold = 1'b1;
        a0 = mem_addra;
        d0 = mem_dina;
        chk("stall_addr", 32'(a0), 32'h011);
        chk("stall_data", d0, 32'h12345678);
        repeat (10) begin
            @(negedge clk);
            chk("stall_addr_stable", 32'(mem_addra), 32'(a0));
            chk("stall_data_stable", mem_dina, d0);
            chk("stall_no_ack", 32'(ack), 32'd0);
        end
        hold = 1'b0;
        wait_ack(n);
        chk("stall_miss", miss_cnt, 32'd4);
        chk("stall_hit", hit_cnt, 32'd7);

        push_line(1'b0, 10'h0A0);
        start(1'b0, 10'h0A0, 32'h0);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(mem_cs && mem_addra == 10'h0A2) && k < 100);
        chk("third_word_seen", 32'(mem_addra), 32'h0A2);
        rst = 1'b1;
        #1;
        chk("arst_mem_cs", 32'(mem_cs), 32'd0);
        chk("arst_hit", hit_cnt, 32'd0);
        chk("arst_miss", miss_cnt, 32'd0);
        exp_mem.delete();
        exp_rd.delete();
        cs = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        push_line(1'b0, 10'h0A0);
        access(1'b0, 10'h0A0, 32'h0, n);
        chk("post_rst_lat", 32'(n), 32'd14);
        chk("post_rst_miss", miss_cnt, 32'd1);
        chk("post_rst_hit", hit_cnt, 32'd1);

        repeat (2) @(posedge clk);
        chk("mem_q_empty", 32'(exp_mem.size()), 32'd0);
        chk("rd_q_empty", 32'(exp_rd.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
